std_mult_seq_32: RTL and testbench

STD_MULT_SEQ_32 -- requirements
Module: std_mult_seq_32

---
 rtl/std_arith_pkg.sv | 12 +
 rtl/std_mult_seq_32.sv | 100 ++++++++++
 tb/tb_std_mult_seq_32.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/std_arith_pkg.sv
// Shared definitions for the sequential arithmetic family (multiplier, divider).
// Holds the control state encoding and the default operand width.
package std_arith_pkg;

  localparam int STD_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } arith_state_t;

endpackage

// File: rtl/std_mult_seq_32.sv
// Sequential shift-add unsigned multiplier. Done pulses WIDTH+1 edges after accept, or 1 edge for a zero operand.
// No backpressure: go is sampled only in IDLE and the result holds until the next start.
module std_mult_seq_32
  import std_arith_pkg::*;
#(
  parameter int WIDTH = STD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  arith_state_t       state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  always_comb begin
    prod_nxt  = mplier[0] ? (prod + mcand) : prod;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      out    <= '0;
      out_hi <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            out    <= '0;
            out_hi <= '0;
            // A zero operand short-circuits: the product is already known.
            if (left == '0 || right == '0) begin
              done <= 1'b1;
            end else begin
              mcand  <= {{WIDTH{1'b0}}, left};
              mplier <= right;
              prod   <= '0;
              cnt    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            {out_hi, out} <= prod_nxt;
            done          <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [WIDTH-1:0]   chk_l;
  logic [WIDTH-1:0]   chk_r;
  logic [2*WIDTH-1:0] chk_prod;

  assign chk_prod = {{WIDTH{1'b0}}, chk_l} * {{WIDTH{1'b0}}, chk_r};

  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_l <= '0;
      chk_r <= '0;
    end else if (state == IDLE && go) begin
      chk_l <= left;
      chk_r <= right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && done && ({out_hi, out} != chk_prod)) begin
      $error("std_mult_seq_32: product %h != %h * %h", {out_hi, out}, chk_l, chk_r);
    end
  end

endmodule

// File: tb/tb_std_mult_seq_32.sv
// Directed bench for std_mult_seq_32: hand-computed products, latency, zero exit, reset abort, back-to-back.
module tb_std_mult_seq_32;
  import std_arith_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [W-1:0]  left = '0;
  logic [W-1:0]  right = '0;
  logic [W-1:0]  out;
  logic [W-1:0]  out_hi;
  logic          done;

  int tests_run = 0;
  int tests_failed = 0;

  std_mult_seq_32 #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .left   (left),
    .right  (right),
    .out    (out),
    .out_hi (out_hi),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Start one operation and wait for done; lat counts edges from accept through the result edge.
  task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r,
                       output int lat, output logic [63:0] res, output logic [63:0] mid);
    @(negedge clk);
    left  = l;
    right = r;
    go    = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    lat = 1;
    mid = {out_hi, out};
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = {out_hi, out};
  endtask

  int          lat;
  int          lat2;
  int          pulses;
  logic [63:0] res;
  logic [63:0] mid;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {out_hi, out}, 64'd0);
    reset = 1'b1;

    // 7 * 6
    do_op(32'd7, 32'd6, lat, res, mid);
    chk("b7x6_lat", 64'(lat), 64'(W + 1));
    chk("b7x6_done", 64'(done), 64'd1);
    chk("b7x6_res", res, 64'd42);
    chk("b7x6_clear", mid, 64'd0);
    @(negedge clk);
    chk("b7x6_pulse", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("b7x6_hold", {out_hi, out}, 64'd42);

    // Largest operands
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, mid);
    chk("max_lat", 64'(lat), 64'(W + 1));
    chk("max_res", res, 64'hFFFF_FFFE_0000_0001);

    do_op(32'h0000_FFFF, 32'h0000_FFFF, lat, res, mid);
    chk("ffff_res", res, 64'h0000_0000_FFFE_0001);

    do_op(32'h8000_0000, 32'h8000_0000, lat, res, mid);
    chk("msb_res", res, 64'h4000_0000_0000_0000);

    // Zero early-exit clears a nonzero previous result and never enters RUN
    do_op(32'd0, 32'h1234, lat, res, mid);
    chk("zl_lat", 64'(lat), 64'd1);
    chk("zl_done", 64'(done), 64'd1);
    chk("zl_res", res, 64'd0);
    chk("zl_idle", 64'(dut.state), 64'(IDLE));
    @(negedge clk);
    chk("zl_pulse", 64'(done), 64'd0);
    do_op(32'h5, 32'h0, lat, res, mid);
    chk("zr_lat", 64'(lat), 64'd1);
    chk("zr_res", res, 64'd0);

    // go and operand changes during RUN are ignored
    @(negedge clk);
    left = 32'd3; right = 32'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    pulses = 0;
    res = '0;
    lat = 0;
    for (int i = 1; i <= W + 10; i++) begin
      if (i == 10) begin go = 1'b1; left = 32'd9; right = 32'd9; end
      if (i == 11) go = 1'b0;
      if (done) begin pulses++; res = {out_hi, out}; if (lat == 0) lat = i; end
      @(negedge clk);
    end
    chk("mid_res", res, 64'd15);
    chk("mid_pulses", 64'(pulses), 64'd1);
    chk("mid_lat", 64'(lat), 64'(W + 1));

    // Reset mid-operation aborts with no done
    @(negedge clk);
    left = 32'h1_0000; right = 32'h1_0000; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", {out_hi, out}, 64'd0);
    pulses = 0;
    for (int i = 0; i < W + 5; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort_nopulse", 64'(pulses), 64'd0);
    do_op(32'd2, 32'd3, lat, res, mid);
    chk("post_rst_lat", 64'(lat), 64'(W + 1));
    chk("post_rst_res", res, 64'd6);

    // go held high: back-to-back operations
    @(negedge clk);
    left = 32'h8000_0000; right = 32'd2; go = 1'b1;
    @(negedge clk);
    left = 32'h10; right = 32'h10;
    lat = 1;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    chk("b2b_lat1", 64'(lat), 64'(W + 1));
    chk("b2b_res1", {out_hi, out}, 64'h0000_0001_0000_0000);
    @(negedge clk);
    chk("b2b_deassert", 64'(done), 64'd0);
    lat2 = 1;
    while (!done && lat2 < 200) begin @(negedge clk); lat2++; end
    go = 1'b0;
    chk("b2b_lat2", 64'(lat2), 64'(W + 1));
    chk("b2b_res2", {out_hi, out}, 64'h0000_0000_0000_0100);
    repeat (W + 4) @(negedge clk);
    chk("b2b_idle", 64'(dut.state), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
